voice_envelope: RTL
===================

# voice_envelope

ADSR envelope generator and amplitude stage for one synth voice. Consumes the unsigned `OUTPUT_BITS` waveform produced by the voice's tone generator and scales it by an 8-bit envelope level driven by a gate input, an attack/decay/sustain/release state machine and a clock prescaler. The output feeds the voice mixer. It is one instance per voice, clocked from the synth system clock.

## Interface
- `OUTPUT_BITS`, 12: width of the waveform in and the scaled waveform out.
- `PRESCALE`, 256: system clocks per envelope base tick; must be ≥2.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `gate`  in  1: note on (1) or off (0); level-sensitive, edge-detected internally.
- `attack`  in  4: attack rate code.
- `decay`  in  4: decay rate code.
- `sustain`  in  4: sustain level code; target level = `{sustain,sustain}` (0..255).
- `release`  in  4: release rate code.
- `din`  in  `OUTPUT_BITS`: unsigned waveform from the tone generator.
- `dout`  out  `OUTPUT_BITS`: scaled waveform, registered.
- `env_level`  out  8: current envelope level.
- `env_state`  out  3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `env_idle`  out  1: high when `env_state`==IDLE.

## Operation
- Gate edge detection:
  - `gate_d` is registered `gate`.
  - rise = `gate & ~gate_d`; fall = `~gate & gate_d`.
- Prescaler:
  - Counter runs 0..`PRESCALE`-1; a base tick is issued in the cycle it equals `PRESCALE`-1, after which it wraps to 0.
  - The rate counter (19 bits) counts base ticks.
- Step condition: rate counter == `(1<<R)<<S` − 1, where:
  - R = rate code of the current state;
  - S = 0, unless the `_EN` feature is on (see Configuration).
- On a step, the rate counter clears and the level moves by 1 LSB.
- Gate edges clear both the prescaler and the rate counter.
- Gate edges are handled identically in every state.
- Transitions:
  - IDLE: level 0. Rise → ATTACK.
  - ATTACK: on a step, level +1. When the level reaches 255 → DECAY in the same cycle. Fall → RELEASE.
  - DECAY: on a step, level −1. When the level ≤ target → SUSTAIN; level is held, not clamped to the target. Fall → RELEASE.
  - SUSTAIN: level held. Changes to `sustain` are ignored until the next note. Fall → RELEASE.
  - RELEASE: on a step, level −1. When the level reaches 0 → IDLE. Rise → ATTACK; attack continues from the current level.
- Entering DECAY with level ≤ target moves to SUSTAIN on the next cycle without stepping. This includes `sustain`=15.
- Priority: a gate edge beats a step in the same cycle. The step is dropped and the counters clear.
- Rise while already in ATTACK cannot occur without an intervening fall. A rise always restarts the counters.
- Amplitude:
  - `dout` <= (`din` × `env_level`) >> 8, full-precision product.
  - Full scale: 4095×255>>8 = 4079.
- Reset clears:
  - `dout`, `env_level`, `gate_d`, the prescaler and the rate counter to 0;
  - `env_state` to IDLE;
  - `env_idle` to 1.
- Reset mid-note returns everything to these values. `gate` held high through reset release produces no rise, because `gate_d` resets to 0 and then samples 1. A bench must pull `gate` low and then high to start a note.

## Timing
- `dout` has one cycle of latency from `din` and `env_level`.
- `env_level` and `env_state` update on the clock edge of the step or edge event.
- The cycle a gate edge takes effect is the first edge where `gate`≠`gate_d`. The state changes on that edge.
- Step period with S=0:
  - `PRESCALE`×2^R clocks;
  - first step `PRESCALE`×2^R clocks after the clearing edge.
- Worst case, R=15 with S=3: the rate counter reaches 2^18 − 1; 19 bits suffice.

## Configuration
- `VOICE_ENVELOPE_EXP_DECAY_EN`
- Defined, in DECAY and RELEASE only, S is chosen from the current level:
  - level ≥128: S=0;
  - 64–127: S=1;
  - 32–63: S=2;
  - <32: S=3.
  - This gives a piecewise-exponential decay curve.
- Undefined: S=0 always, giving linear decay and release.
- ATTACK is always linear.

## Test plan
- Reset with `din`=4095 → `dout`=0, `env_level`=0, `env_state`=0, `env_idle`=1.
- `PRESCALE`=4, `attack`=0, `decay`=0, `sustain`=8, then gate rise → ATTACK:
  - level 255 after 1020 clocks, then DECAY;
  - SUSTAIN at level 136 after a further 476 clocks.
- In SUSTAIN with `din`=4095 → `dout`=(4095×136)>>8=2175 one cycle after the level settles.
- Gate fall in SUSTAIN with `release`=1 and `PRESCALE`=4 → level 0 after 136×8 clocks, then IDLE with `env_idle`=1 (macro undefined).
- Gate rise during RELEASE at level 100 → ATTACK resumes from 100, not from 0; the first step comes `PRESCALE` clocks later.
- Macro defined, `release`=0, `PRESCALE`=4, from level 255 → 0 takes (128×1 + 64×2 + 32×4 + 31×8)×4 = 2528 clocks (last step at level 1→0).

Source files
------------

// File: rtl/voice_envelope.sv
// voice_envelope: ADSR envelope generator and amplitude stage for one synth voice.
// Define VOICE_ENVELOPE_EXP_DECAY_EN for a piecewise-exponential decay/release curve.
module voice_envelope #(
  parameter int OUTPUT_BITS = 12,
  parameter int PRESCALE    = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gate,
  input  logic [3:0]             attack,
  input  logic [3:0]             decay,
  input  logic [3:0]             sustain,
  input  logic [3:0]             release_code,
  input  logic [OUTPUT_BITS-1:0] din,
  output logic [OUTPUT_BITS-1:0] dout,
  output logic [7:0]             env_level,
  output logic [2:0]             env_state,
  output logic                   env_idle
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t                 state_q, state_d;
  logic [7:0]             level_q, level_d;
  logic [7:0]             target_q, target_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [18:0]            rate_q, rate_d;
  logic [OUTPUT_BITS-1:0] dout_q, dout_d;
  logic                   gate_dly_q, gate_dly_d;

  logic [3:0]             rate_code;
  logic [1:0]             s_sel;
  logic [18:0]            limit;
  logic                   tick, step, rise, fall;
  logic [OUTPUT_BITS+7:0] prod;

  assign rise  = gate & ~gate_dly_q;
  assign fall  = ~gate & gate_dly_q;
  assign tick  = (presc_q == PRESC_LAST);
  assign limit = ((19'd1 << rate_code) << s_sel) - 19'd1;
  assign step  = tick && (rate_q == limit);
  assign prod  = {8'd0, din} * {{OUTPUT_BITS{1'b0}}, level_q};

  always_comb begin
    rate_code = attack;
    case (state_q)
      DECAY:   rate_code = decay;
      RELEASE: rate_code = release_code;
      default: rate_code = attack;
    endcase
  end

  // Longer step periods at low levels bend decay/release into an exponential-like curve.
  always_comb begin
    s_sel = 2'd0;
`ifdef VOICE_ENVELOPE_EXP_DECAY_EN
    if (state_q == DECAY || state_q == RELEASE) begin
      if (level_q[7])      s_sel = 2'd0;
      else if (level_q[6]) s_sel = 2'd1;
      else if (level_q[5]) s_sel = 2'd2;
      else                 s_sel = 2'd3;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    target_d   = target_q;
    gate_dly_d = gate;
    dout_d     = OUTPUT_BITS'(prod >> 8);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    rate_d     = rate_q;
    if (tick) rate_d = step ? 19'd0 : rate_q + 19'd1;

    if (rise || fall) begin
      presc_d = '0;
      rate_d  = '0;
      if (rise) begin
        state_d  = ATTACK;
        target_d = {sustain, sustain};
      end else begin
        state_d = RELEASE;
      end
    end else begin
      case (state_q)
        IDLE: level_d = 8'd0;
        ATTACK: begin
          if (level_q == 8'hFF) begin
            state_d = DECAY;
          end else if (step) begin
            level_d = level_q + 8'd1;
            if (level_d == 8'hFF) state_d = DECAY;
          end
        end
        DECAY: begin
          if (level_q <= target_q) begin
            state_d = SUSTAIN;
          end else if (step) begin
            level_d = level_q - 8'd1;
            if (level_d <= target_q) state_d = SUSTAIN;
          end
        end
        SUSTAIN: state_d = SUSTAIN;
        RELEASE: begin
          if (level_q == 8'd0) begin
            state_d = IDLE;
          end else if (step) begin
            level_d = level_q - 8'd1;
            if (level_d == 8'd0) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      level_q    <= 8'd0;
      target_q   <= 8'd0;
      presc_q    <= '0;
      rate_q     <= 19'd0;
      dout_q     <= '0;
      gate_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      target_q   <= target_d;
      presc_q    <= presc_d;
      rate_q     <= rate_d;
      dout_q     <= dout_d;
      gate_dly_q <= gate_dly_d;
    end
  end

  assign dout      = dout_q;
  assign env_level = level_q;
  assign env_state = state_q;
  assign env_idle  = (state_q == IDLE);

endmodule
